// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the I/D-cache memory arbiter.
package mem_arb_pkg;

    localparam int unsigned BLK_WORDS_DEF = 8;
    localparam int unsigned IDX_W_DEF     = $clog2(BLK_WORDS_DEF);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

endpackage

// File: rtl/arb_rr2.sv
// Two-way round-robin decision: on a tie, grant the requester not granted last.
module arb_rr2
    import mem_arb_pkg::*;
(
    input  logic [1:0] i_req,
    input  owner_t     i_last,
    output logic [1:0] o_gnt
);

    // o_gnt[0] = I-cache, o_gnt[1] = D-cache
    always_comb begin
        o_gnt = i_req;
        if (i_req == 2'b11) begin
            o_gnt = (i_last == OWN_I) ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one main-memory port between I-cache block fills and D-cache
// fills / write-throughs; one owner at a time, latched at grant.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter  int unsigned BLK_WORDS = BLK_WORDS_DEF,
    parameter  int unsigned ADDR_W    = 16,
    localparam int unsigned IW        = $clog2(BLK_WORDS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              d_req,
    input  logic              d_wr,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [15:0]       d_wdata,
    output logic              i_done,
    output logic              d_done,
    output logic [15:0]       fill_data,
    output logic [IW-1:0]     fill_idx,
    output logic              fill_we_i,
    output logic              fill_we_d,
    output logic              mem_en,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    input  logic [15:0]       mem_rdata,
    input  logic              mem_valid
);

    localparam logic [IW-1:0] LAST = IW'(BLK_WORDS - 1);

    state_t                 r_state;
    owner_t                 r_owner;
    owner_t                 r_last;
    logic [IW-1:0]          r_k;
    logic [IW-1:0]          r_rx;
    logic [ADDR_W-IW-2:0]   r_base;

    logic [1:0]             w_gnt;
    logic [ADDR_W-1:0]      w_sel_addr;
    logic                   w_acc;
    logic                   w_unused;

    arb_rr2 u_arb (
        .i_req  ({d_req, i_req}),
        .i_last (r_last),
        .o_gnt  (w_gnt)
    );

    assign w_sel_addr = w_gnt[1] ? d_addr : i_addr;
    assign w_unused   = ^w_sel_addr[IW:0];

    // Returned words pass straight through in the cycle memory presents them.
    assign w_acc     = (r_state == ST_FILL) && mem_valid;
    assign fill_we_i = w_acc && (r_owner == OWN_I);
    assign fill_we_d = w_acc && (r_owner == OWN_D);
    assign fill_data = w_acc ? mem_rdata : '0;
    assign fill_idx  = w_acc ? r_rx : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_owner   <= OWN_I;
            r_last    <= OWN_I;
            r_k       <= '0;
            r_rx      <= '0;
            r_base    <= '0;
            mem_en    <= 1'b0;
            mem_wr    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            i_done    <= 1'b0;
            d_done    <= 1'b0;
        end else begin
            i_done <= 1'b0;
            d_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (|w_gnt) begin
                        r_owner <= w_gnt[1] ? OWN_D : OWN_I;
                        r_last  <= w_gnt[1] ? OWN_D : OWN_I;
                        r_k     <= '0;
                        r_rx    <= '0;
                        r_base  <= w_sel_addr[ADDR_W-1:IW+1];
                        mem_en  <= 1'b1;
                        if (w_gnt[1] && d_wr) begin
                            r_state   <= ST_WRITE;
                            mem_wr    <= 1'b1;
                            mem_addr  <= d_addr;
                            mem_wdata <= d_wdata;
                        end else begin
                            r_state  <= ST_FILL;
                            mem_addr <= {w_sel_addr[ADDR_W-1:IW+1], {IW{1'b0}}, 1'b0};
                        end
                    end
                end
                ST_FILL: begin
                    if (mem_en) begin
                        if (r_k == LAST) begin
                            mem_en   <= 1'b0;
                            mem_addr <= '0;
                        end else begin
                            r_k      <= r_k + 1'b1;
                            mem_addr <= {r_base, r_k + 1'b1, 1'b0};
                        end
                    end
                    // Last word closes the fill even if issue is still in flight.
                    if (mem_valid) begin
                        if (r_rx == LAST) begin
                            r_state  <= ST_DONE;
                            mem_en   <= 1'b0;
                            mem_addr <= '0;
                            i_done   <= (r_owner == OWN_I);
                            d_done   <= (r_owner == OWN_D);
                        end else begin
                            r_rx <= r_rx + 1'b1;
                        end
                    end
                end
                ST_WRITE: begin
                    r_state   <= ST_DONE;
                    mem_en    <= 1'b0;
                    mem_wr    <= 1'b0;
                    mem_addr  <= '0;
                    mem_wdata <= '0;
                    i_done    <= (r_owner == OWN_I);
                    d_done    <= (r_owner == OWN_D);
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: expected memory commands, fill writes and
// done pulses are queued at stimulus time and matched by a negedge monitor.
module tb_mem_arbiter;

    localparam int unsigned LAT = 4;

    logic        clk, rst;
    logic        i_req, d_req, d_wr;
    logic [15:0] i_addr, d_addr, d_wdata;
    logic        i_done, d_done;
    logic [15:0] fill_data;
    logic [2:0]  fill_idx;
    logic        fill_we_i, fill_we_d;
    logic        mem_en, mem_wr;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_valid;

    typedef struct packed {
        logic        wr;
        logic [15:0] addr;
        logic [15:0] wdata;
    } mem_ev_t;

    typedef struct packed {
        logic        d;
        logic [2:0]  idx;
        logic [15:0] data;
    } fill_ev_t;

    typedef struct {
        logic [15:0] a;
        int unsigned due;
    } rd_t;

    mem_ev_t     q_mem[$];
    fill_ev_t    q_fill[$];
    logic        q_done[$];
    rd_t         pend[$];

    mem_ev_t     em;
    fill_ev_t    ef;
    logic        ed;

    int unsigned n_pass = 0;
    int unsigned n_total = 0;
    int unsigned cyc = 0;
    int unsigned fill_cnt = 0;
    int unsigned done_cyc = 0;
    int unsigned k_base, k_t;
    logic        after_done = 1'b0;
    logic        gap_on = 1'b0;
    logic        spur = 1'b0;

    mem_arbiter #(.BLK_WORDS(8), .ADDR_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .d_req     (d_req),
        .d_wr      (d_wr),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .i_done    (i_done),
        .d_done    (d_done),
        .fill_data (fill_data),
        .fill_idx  (fill_idx),
        .fill_we_i (fill_we_i),
        .fill_we_d (fill_we_d),
        .mem_en    (mem_en),
        .mem_wr    (mem_wr),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_valid (mem_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] mdata(input logic [15:0] a);
        return a ^ 16'hC3A5;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_ctrl"}, 32'({fill_we_i, fill_we_d, i_done, d_done, mem_en, mem_wr}), 32'd0);
        chk({nm, "_mem_addr"}, 32'(mem_addr), 32'd0);
        chk({nm, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
        chk({nm, "_fill_data"}, 32'(fill_data), 32'd0);
        chk({nm, "_fill_idx"}, 32'(fill_idx), 32'd0);
    endtask

    task automatic exp_fill(input logic own_d, input logic [15:0] a);
        logic [15:0] ak;
        for (int k = 0; k < 8; k++) begin
            ak = {a[15:4], 3'(k), 1'b0};
            q_mem.push_back('{wr: 1'b0, addr: ak, wdata: 16'h0000});
            q_fill.push_back('{d: own_d, idx: 3'(k), data: mdata(ak)});
        end
        q_done.push_back(own_d);
    endtask

    task automatic exp_write(input logic [15:0] a, input logic [15:0] wd);
        q_mem.push_back('{wr: 1'b1, addr: a, wdata: wd});
        q_done.push_back(1'b1);
    endtask

    task automatic req_d(input logic [15:0] a, input logic w, input logic [15:0] wd);
        int unsigned t;
        d_addr = a; d_wr = w; d_wdata = wd; d_req = 1'b1;
        t = 0;
        do begin @(negedge clk); t++; end while (!d_done && t < 400);
        if (!d_done) chk("d_done_timeout", 32'(d_done), 32'd1);
        @(posedge clk); #1;
        d_req = 1'b0; d_wr = 1'b0;
    endtask

    task automatic req_i(input logic [15:0] a);
        int unsigned t;
        i_addr = a; i_req = 1'b1;
        t = 0;
        do begin @(negedge clk); t++; end while (!i_done && t < 400);
        if (!i_done) chk("i_done_timeout", 32'(i_done), 32'd1);
        @(posedge clk); #1;
        i_req = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        #1 chk_zero("rst");
        repeat (2) @(negedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
    endtask

    // Memory model: fixed latency, one response per cycle, data = mdata(addr).
    initial begin
        mem_valid = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk); #1;
            cyc++;
            if (!rst) begin
                pend.delete();
                mem_valid = 1'b0;
                mem_rdata = '0;
            end else if (spur) begin
                mem_valid = 1'b1;
                mem_rdata = 16'hDEAD;
            end else if (pend.size() > 0 && pend[0].due <= cyc) begin
                mem_valid = 1'b1;
                mem_rdata = mdata(pend[0].a);
                void'(pend.pop_front());
            end else begin
                mem_valid = 1'b0;
                mem_rdata = '0;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            after_done = 1'b0;
        end else begin
            if (mem_en) begin
                if (q_mem.size() == 0) begin
                    chk("mem_unexpected", 32'(mem_en), 32'd0);
                end else begin
                    em = q_mem.pop_front();
                    chk("mem_wr", 32'(mem_wr), 32'(em.wr));
                    chk("mem_addr", 32'(mem_addr), 32'(em.addr));
                    if (em.wr) chk("mem_wdata", 32'(mem_wdata), 32'(em.wdata));
                end
                if (!mem_wr) pend.push_back('{a: mem_addr, due: cyc + LAT});
                if (gap_on && after_done) chk("grant_gap", 32'(cyc - done_cyc), 32'd2);
                after_done = 1'b0;
            end
            if (fill_we_i || fill_we_d) begin
                if (q_fill.size() == 0) begin
                    chk("fill_unexpected", 32'({fill_we_i, fill_we_d}), 32'd0);
                end else begin
                    ef = q_fill.pop_front();
                    chk("fill_we", 32'({fill_we_d, fill_we_i}), ef.d ? 32'd2 : 32'd1);
                    chk("fill_idx", 32'(fill_idx), 32'(ef.idx));
                    chk("fill_data", 32'(fill_data), 32'(ef.data));
                end
                fill_cnt++;
            end
            if (i_done || d_done) begin
                if (q_done.size() == 0) begin
                    chk("done_unexpected", 32'({i_done, d_done}), 32'd0);
                end else begin
                    ed = q_done.pop_front();
                    chk("done_owner", 32'({d_done, i_done}), ed ? 32'd2 : 32'd1);
                end
                after_done = 1'b1;
                done_cyc = cyc;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        i_req = 1'b0; d_req = 1'b0; d_wr = 1'b0;
        i_addr = '0; d_addr = '0; d_wdata = '0;
        #1 chk_zero("por");
        repeat (2) @(negedge clk);
        #1 rst = 1'b1;

        // Spurious mem_valid while idle must not write any cache.
        @(negedge clk);
        spur = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("spur_idle_quiet", 32'({fill_we_i, fill_we_d, mem_en, d_done, i_done}), 32'd0);
            chk("spur_fill_data", 32'(fill_data), 32'd0);
        end
        spur = 1'b0;
        @(negedge clk);

        // Write-through requested during reset: granted on the first edge after release.
        rst = 1'b0;
        #1 chk_zero("rst_w");
        exp_write(16'hAAAA, 16'hBBBB);
        fork
            req_d(16'hAAAA, 1'b1, 16'hBBBB);
            begin
                repeat (2) begin
                    @(negedge clk);
                    chk("rst_hold_mem_en", 32'(mem_en), 32'd0);
                end
                #1 rst = 1'b1;
                @(negedge clk);
                chk("first_grant_write", 32'({mem_en, mem_wr}), 32'd3);
            end
        join

        // D-cache fill at 0x1234: reads 0x1230..0x123E.
        do_reset();
        exp_fill(1'b1, 16'h1234);
        req_d(16'h1234, 1'b0, 16'h0000);

        // Simultaneous I and D reads after reset: D first, then I.
        do_reset();
        gap_on = 1'b1;
        exp_fill(1'b1, 16'h4000);
        exp_fill(1'b0, 16'h8A50);
        fork
            req_d(16'h4000, 1'b0, 16'h0000);
            req_i(16'h8A50);
        join

        // Both requesters kept busy: grants alternate D, I, D, I.
        do_reset();
        exp_fill(1'b1, 16'h1000);
        exp_fill(1'b0, 16'h2000);
        exp_write(16'h3000, 16'h5555);
        exp_fill(1'b0, 16'h4000);
        fork
            begin
                req_d(16'h1000, 1'b0, 16'h0000);
                req_d(16'h3000, 1'b1, 16'h5555);
            end
            begin
                req_i(16'h2000);
                req_i(16'h4000);
            end
        join
        gap_on = 1'b0;

        // Reset after the third fill word; the held request restarts at word 0.
        do_reset();
        exp_fill(1'b1, 16'h5670);
        fork
            req_d(16'h5670, 1'b0, 16'h0000);
            begin
                k_base = fill_cnt;
                k_t = 0;
                while (fill_cnt < k_base + 3 && k_t < 200) begin
                    @(negedge clk); #2;
                    k_t++;
                end
                rst = 1'b0;
                #1 chk_zero("midfill");
                q_mem.delete();
                q_fill.delete();
                q_done.delete();
                exp_fill(1'b1, 16'h5670);
                repeat (2) @(negedge clk);
                #1 rst = 1'b1;
            end
        join

        repeat (6) @(negedge clk);
        chk("mem_q_left", 32'(q_mem.size()), 32'd0);
        chk("fill_q_left", 32'(q_fill.size()), 32'd0);
        chk("done_q_left", 32'(q_done.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
